// File: rtl/huffman_coder_ctrl_if.sv
// Purpose: stream bundle between the Huffman coder controller and its host.
//   Symbol input stream : s_valid, s_ready, s_sym
//   Word output stream  : m_valid, m_ready, m_data, m_last, m_bits
// Modports:
//   slave  - controller side (consumes symbols, produces words)
//   master - host side (produces symbols, consumes words)
interface huffman_coder_ctrl_if #(
    parameter int SYM_W = 4
);
    logic             s_valid;
    logic             s_ready;
    logic [SYM_W-1:0] s_sym;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;
    logic [5:0]       m_bits;

    modport slave (
        input  s_valid, s_sym, m_ready,
        output s_ready, m_valid, m_data, m_last, m_bits
    );

    modport master (
        output s_valid, s_sym, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_bits
    );
endinterface

// File: rtl/huffman_coder_ctrl.sv
// Purpose: sequencer and codebook for a 32-bit Huffman bit-packer. Maps
// accepted symbols to code/length through a loadable codebook, drives the
// packer, mirrors its bit count, buffers each emitted word in a 1-deep
// output register and zero-pads/tags the final word on flush.
// Ports:
//   clock, resetn          - clock, synchronous active-low reset
//   i_cfg_we/addr/code/len - codebook write (IDLE only, len clamped to 8)
//   i_start, i_flush       - begin message (IDLE) / end message (RUN)
//   o_p_ce/resetn/code/length, i_p_word - packer control and result word
//   o_word_cnt, o_busy, o_done - words taken, not-idle, end-of-message pulse
//   bus                    - symbol and word streams (slave modport)
module huffman_coder_ctrl #(
    parameter int SYM_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_cfg_we,
    input  logic [SYM_W-1:0] i_cfg_addr,
    input  logic [7:0]       i_cfg_code,
    input  logic [3:0]       i_cfg_len,
    input  logic             i_start,
    input  logic             i_flush,
    output logic             o_p_ce,
    output logic             o_p_resetn,
    output logic [7:0]       o_p_code,
    output logic [3:0]       o_p_length,
    input  logic [31:0]      i_p_word,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic             o_busy,
    output logic             o_done,
    huffman_coder_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

    state_t           r_state;
    logic             r_clr_second;
    logic             r_pend;
    logic [7:0]       r_code;
    logic [3:0]       r_len;
    logic [5:0]       r_acc;
    logic [5:0]       r_pad;
    logic             r_m_valid;
    logic             r_m_last;
    logic [31:0]      r_m_data;
    logic [5:0]       r_m_bits;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_done;

    logic [7:0]       r_cb_code [2**SYM_W];
    logic [3:0]       r_cb_len  [2**SYM_W];

    logic             w_full;
    logic             w_stall;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_pad_push;
    logic             w_push;
    logic [3:0]       w_pad_len;
    logic [3:0]       w_len;
    logic [7:0]       w_code;
    logic [5:0]       w_acc_next;
    logic             w_emit;
    logic             w_last;

    assign w_full    = (r_acc >= 6'd32);
    assign w_stall   = w_full && r_m_valid && !bus.m_ready;
    assign w_s_ready = (r_state == RUN) && !w_stall;
    assign w_accept  = bus.s_valid && w_s_ready;

    // Padding only starts once the last real symbol has been pushed.
    assign w_pad_push = (r_state == FLUSH) && !r_pend && (r_acc != 6'd0);
    assign w_push     = !w_stall && (r_pend || w_pad_push);

    // For acc in 25..31, 32-acc equals (-acc) mod 16 on the low nibble.
    assign w_pad_len  = w_full ? 4'd0 :
                        (r_acc > 6'd24) ? (4'd0 - r_acc[3:0]) : 4'd8;
    assign w_len      = r_pend ? r_len  : w_pad_len;
    assign w_code     = r_pend ? r_code : 8'd0;
    assign w_acc_next = w_full ? (r_acc - 6'd32 + {2'b00, w_len})
                               : (r_acc + {2'b00, w_len});
    assign w_emit     = w_push && w_full;
    // The word that drains the packer to empty during FLUSH is the last one.
    assign w_last     = (r_state == FLUSH) && (w_acc_next == 6'd0);

    assign o_p_ce     = (r_state == CLEAR) || w_push;
    assign o_p_resetn = (r_state != CLEAR);
    assign o_p_code   = w_push ? w_code : 8'd0;
    assign o_p_length = w_push ? w_len  : 4'd0;
    assign o_word_cnt = r_word_cnt;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign bus.m_bits  = r_m_bits;

    always_ff @(posedge clock) begin
        if (i_cfg_we && (r_state == IDLE)) begin
            r_cb_code[i_cfg_addr] <= i_cfg_code;
            r_cb_len[i_cfg_addr]  <= (i_cfg_len > 4'd8) ? 4'd8 : i_cfg_len;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_clr_second <= 1'b0;
            r_pend       <= 1'b0;
            r_code       <= '0;
            r_len        <= '0;
            r_acc        <= '0;
            r_pad        <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
            r_m_bits     <= '0;
            r_word_cnt   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_push)
                r_acc <= w_acc_next;

            if (w_accept) begin
                r_pend <= 1'b1;
                r_code <= r_cb_code[bus.s_sym];
                r_len  <= r_cb_len[bus.s_sym];
            end else if (w_push) begin
                r_pend <= 1'b0;
            end

            if (w_pad_push && w_push)
                r_pad <= r_pad + {2'b00, w_len};

            if (w_emit) begin
                r_m_valid <= 1'b1;
                r_m_data  <= i_p_word;
                r_m_last  <= w_last;
                r_m_bits  <= w_last ? (6'd32 - r_pad) : 6'd32;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            if (r_m_valid && bus.m_ready && (r_word_cnt != '1))
                r_word_cnt <= r_word_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state      <= CLEAR;
                        r_clr_second <= 1'b0;
                        r_pend       <= 1'b0;
                        r_acc        <= '0;
                        r_pad        <= '0;
                        r_word_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    r_acc        <= '0;
                    r_clr_second <= 1'b1;
                    if (r_clr_second)
                        r_state <= RUN;
                end
                RUN: begin
                    if (i_flush)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    if (!r_pend && (r_acc == 6'd0)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_coder_ctrl.sv
// Purpose: directed self-checking bench for huffman_coder_ctrl with a
// behavioural model of the 32-bit LSB-first bit-packer it drives.
module tb_huffman_coder_ctrl;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_code = '0;
    logic [3:0]  cfg_len = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        p_ce, p_resetn;
    logic [7:0]  p_code;
    logic [3:0]  p_length;
    logic [31:0] p_word;
    logic [15:0] word_cnt;
    logic        busy, done;

    always #5 clock = ~clock;

    huffman_coder_ctrl_if #(.SYM_W(4)) bus();

    huffman_coder_ctrl #(.SYM_W(4), .CNT_W(16)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_code (cfg_code),
        .i_cfg_len  (cfg_len),
        .i_start    (start),
        .i_flush    (flush),
        .o_p_ce     (p_ce),
        .o_p_resetn (p_resetn),
        .o_p_code   (p_code),
        .o_p_length (p_length),
        .i_p_word   (p_word),
        .o_word_cnt (word_cnt),
        .o_busy     (busy),
        .o_done     (done),
        .bus        (bus.slave)
    );

    // Packer model: appends length bits of code LSB-first; once 32 bits are
    // held, the next push drops that word and appends after the remainder.
    logic [39:0] pk_buf = '0;
    logic [5:0]  pk_cnt = '0;
    logic [39:0] pk_bits;
    assign pk_bits = {32'd0, p_code} & ((40'd1 << p_length) - 40'd1);
    assign p_word  = pk_buf[31:0];

    always @(posedge clock) begin
        if (p_ce) begin
            if (!p_resetn) begin
                pk_buf <= '0;
                pk_cnt <= '0;
            end else if (pk_cnt >= 6'd32) begin
                pk_buf <= (pk_buf >> 32) | (pk_bits << (pk_cnt - 6'd32));
                pk_cnt <= pk_cnt - 6'd32 + {2'b00, p_length};
            end else begin
                pk_buf <= pk_buf | (pk_bits << pk_cnt);
                pk_cnt <= pk_cnt + {2'b00, p_length};
            end
        end
    end

    // Word record: {last, bits[5:0], data[31:0]}
    typedef logic [38:0] wrec_t;
    wrec_t got[$];
    int    done_cnt = 0;

    // Inputs change 2 time units after the rising edge, so the falling edge
    // sees exactly the values the next rising edge will act on.
    always @(negedge clock) begin
        if (resetn) begin
            if (bus.m_valid && bus.m_ready)
                got.push_back({bus.m_last, bus.m_bits, bus.m_data});
            if (done)
                done_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic wrec_t gw(input int i);
        if (i < got.size())
            return got[i];
        return '1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] c, input logic [3:0] l);
        cfg_we = 1'b1; cfg_addr = a; cfg_code = c; cfg_len = l;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_msg();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int c = 0;
        while (!bus.s_ready && c < 20) begin
            tick();
            c++;
        end
        check(tag, bus.s_ready, 1);
    endtask

    task automatic send_syms(input string tag, input int n, input int base, input int step);
        int i = 0;
        int c = 0;
        while (i < n && c < 200) begin
            bus.s_valid = 1'b1;
            bus.s_sym   = 4'(base + i * step);
            @(negedge clock);
            if (bus.s_ready)
                i++;
            tick();
            c++;
        end
        bus.s_valid = 1'b0;
        check(tag, i, n);
    endtask

    task automatic flush_and_wait(input string tag);
        int d0 = done_cnt;
        int c = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (done_cnt == d0 && c < 100) begin
            tick();
            c++;
        end
        check(tag, done_cnt - d0, 1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        bus.s_valid = 1'b0;
        bus.s_sym   = '0;
        bus.m_ready = 1'b0;

        tick(); tick(); tick();
        check("rst_busy",     busy, 0);
        check("rst_m_valid",  bus.m_valid, 0);
        check("rst_p_resetn", p_resetn, 1);
        check("rst_p_ce",     p_ce, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_done",     done, 0);
        check("rst_s_ready",  bus.s_ready, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 16; i++)
            cfg_write(4'(i), 8'(i), 4'd4);
        bus.m_ready = 1'b1;

        // 8 symbols of 4 bits fill exactly one word
        got.delete();
        start_msg();
        check("t1_clr1_ce",   p_ce, 1);
        check("t1_clr1_rstn", p_resetn, 0);
        check("t1_clr1_len",  p_length, 0);
        check("t1_busy",      busy, 1);
        tick();
        check("t1_clr2_rstn", p_resetn, 0);
        tick();
        check("t1_run_rstn",  p_resetn, 1);
        check("t1_run_ready", bus.s_ready, 1);
        send_syms("t1_send", 8, 0, 1);
        flush_and_wait("t1_done");
        check("t1_nwords", got.size(), 1);
        check("t1_w0",     gw(0), {1'b1, 6'd32, 32'h76543210});
        check("t1_cnt",    word_cnt, 1);
        check("t1_idle",   busy, 0);

        // 36 bits: full word then a 4-bit padded last word
        got.delete();
        start_msg();
        wait_run("t2_run");
        send_syms("t2_send", 9, 0, 1);
        flush_and_wait("t2_done");
        check("t2_nwords", got.size(), 2);
        check("t2_w0",     gw(0), {1'b0, 6'd32, 32'h76543210});
        check("t2_w1",     gw(1), {1'b1, 6'd4,  32'h00000008});
        check("t2_cnt",    word_cnt, 2);

        // Backpressure: output held full, symbols stall once acc reaches 32
        got.delete();
        start_msg();
        wait_run("t3_run");
        bus.m_ready = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 30; c++) begin
            bus.s_valid = 1'b1;
            bus.s_sym   = 4'(acc_n);
            @(negedge clock);
            if (bus.s_ready)
                acc_n++;
            tick();
        end
        check("t3_accepted", acc_n, 17);
        check("t3_stall",    bus.s_ready, 0);
        check("t3_m_valid",  bus.m_valid, 1);
        check("t3_m_data",   bus.m_data, 32'h76543210);
        check("t3_none_yet", got.size(), 0);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40 && acc_n < 20; c++) begin
            bus.s_valid = 1'b1;
            bus.s_sym   = 4'(acc_n);
            @(negedge clock);
            if (bus.s_ready)
                acc_n++;
            tick();
        end
        bus.s_valid = 1'b0;
        check("t3_resumed", acc_n, 20);
        flush_and_wait("t3_done");
        check("t3_nwords", got.size(), 3);
        check("t3_w0",     gw(0), {1'b0, 6'd32, 32'h76543210});
        check("t3_w1",     gw(1), {1'b0, 6'd32, 32'hFEDCBA98});
        check("t3_w2",     gw(2), {1'b1, 6'd16, 32'h00003210});
        check("t3_cnt",    word_cnt, 3);

        // Empty message: done two cycles after flush, no word
        got.delete();
        start_msg();
        wait_run("t4_run");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_done_early", done, 0);
        tick();
        check("t4_done_pulse", done, 1);
        tick();
        check("t4_done_once",  done, 0);
        tick();
        check("t4_nwords", got.size(), 0);
        check("t4_cnt",    word_cnt, 0);
        check("t4_idle",   busy, 0);

        // Reset mid-message drops the pending word; codebook survives
        got.delete();
        start_msg();
        wait_run("t6_run");
        bus.m_ready = 1'b0;
        send_syms("t6_send", 9, 0, 1);
        tick(); tick(); tick();
        check("t6_mvalid_before", bus.m_valid, 1);
        resetn = 1'b0;
        tick();
        check("t6_mvalid_after", bus.m_valid, 0);
        check("t6_busy_after",   busy, 0);
        check("t6_ready_after",  bus.s_ready, 0);
        resetn = 1'b1;
        bus.m_ready = 1'b1;
        got.delete();
        start_msg();
        wait_run("t6_run2");
        send_syms("t6_send2", 8, 0, 1);
        flush_and_wait("t6_done");
        check("t6_nwords", got.size(), 1);
        check("t6_w0",     gw(0), {1'b1, 6'd32, 32'h76543210});

        // Length 12 clamps to 8; a codebook write during RUN is ignored
        cfg_write(4'd5, 8'hA5, 4'd12);
        got.delete();
        start_msg();
        wait_run("t5_run");
        send_syms("t5_send1", 2, 5, 0);
        cfg_write(4'd5, 8'h3C, 4'd4);
        send_syms("t5_send2", 2, 5, 0);
        flush_and_wait("t5_done");
        check("t5_nwords", got.size(), 1);
        check("t5_w0",     gw(0), {1'b1, 6'd32, 32'hA5A5A5A5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
